core_sequencer: RTL and testbench

Parametrised multi-cycle execution sequencer for the RV32I core; it replaces the free-running single-cycle PC register. It owns the PC and steps each instruction through fetch, execute, memory and writeback. Instruction and data memories have variable latency and use req/ack handshakes. Missing acks and misaligned jumps raise a trap, and every completed instruction is counted as retired.

---
 rtl/core_sequencer.sv | 125 ++++++++++++
 tb/tb_core_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I instruction sequencer: owns the PC and walks each instruction
// through FETCH/EXEC/MEM/WB with handshake timeouts, trap redirection and retire counting.
module core_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              TIMEOUT   = 16
) (
  input  logic            sysclk,
  input  logic            rst_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [31:0]     imem_data_in,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  input  logic [XLEN-1:0] pc_next_in,
  input  logic [1:0]      mem_op_in,
  output logic            dmem_req_out,
  output logic            dmem_we_out,
  input  logic            dmem_ack_in,
  input  logic [31:0]     dmem_rd_data_in,
  output logic [31:0]     load_data_out,
  input  logic            reg_wr_en_in,
  output logic            reg_wr_en_out,
  output logic            retire_out,
  output logic [31:0]     instret_out,
  output logic            trap_out,
  output logic [1:0]      trap_cause_out
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q, ld_q, instret_q;
  logic [1:0]      cause_q;
  logic [CW-1:0]   cnt_q;

  logic is_ld, is_st, pc_ok, tmo;
  assign is_ld = (mem_op_in == 2'b01);
  assign is_st = (mem_op_in == 2'b10);
  assign pc_ok = (pc_next_in[1:0] == 2'b00);
  assign tmo   = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VEC;
      instr_q   <= 32'h0000_0013;
      ld_q      <= '0;
      instret_q <= '0;
      cause_q   <= 2'b00;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          cnt_q   <= '0;
        end
        S_FETCH: begin
          // an ack on the final countdown cycle beats the timeout
          if (imem_ack_in) begin
            instr_q <= imem_data_in;
            state_q <= S_EXEC;
          end else if (tmo) begin
            cause_q <= 2'b01;
            state_q <= S_TRAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_EXEC: begin
          cnt_q   <= '0;
          state_q <= (is_ld || is_st) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ack_in) begin
            if (is_ld) ld_q <= dmem_rd_data_in;
            state_q <= S_WB;
          end else if (tmo) begin
            cause_q <= 2'b10;
            state_q <= S_TRAP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WB: begin
          if (!pc_ok) begin
            cause_q <= 2'b11;
            state_q <= S_TRAP;
          end else begin
            pc_q      <= pc_next_in;
            instret_q <= instret_q + 32'd1;
            cnt_q     <= '0;
            state_q   <= S_FETCH;
          end
        end
        S_TRAP: begin
          pc_q    <= TRAP_VEC;
          cnt_q   <= '0;
          state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // strobes decode straight from the state register so reset drops them at once
  assign imem_req_out   = (state_q == S_FETCH);
  assign imem_addr_out  = pc_q;
  assign pc_out         = pc_q;
  assign instr_out      = instr_q;
  assign dmem_req_out   = (state_q == S_MEM);
  assign dmem_we_out    = (state_q == S_MEM) && is_st;
  assign load_data_out  = ld_q;
  assign retire_out     = (state_q == S_WB) && pc_ok;
  assign reg_wr_en_out  = (state_q == S_WB) && pc_ok && reg_wr_en_in;
  assign instret_out    = instret_q;
  assign trap_out       = (state_q == S_TRAP);
  assign trap_cause_out = cause_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboarded bench for core_sequencer: expected retire/trap events are queued as
// each instruction is launched and checked when the DUT pulses retire_out/trap_out.
module tb_core_sequencer;
  logic        sysclk = 0, rst_in = 1;
  logic        imem_req_out, imem_ack_in = 0;
  logic [31:0] imem_addr_out, imem_data_in = 32'h13, instr_out, pc_out, pc_next_in;
  logic [1:0]  mem_op_in = 0, trap_cause_out;
  logic        dmem_req_out, dmem_we_out, dmem_ack_in = 0;
  logic [31:0] dmem_rd_data_in = 0, load_data_out, instret_out;
  logic        reg_wr_en_in = 1, reg_wr_en_out, retire_out, trap_out;
  logic        use_tgt = 0;
  logic [31:0] pc_tgt = 0;

  assign pc_next_in = use_tgt ? pc_tgt : pc_out + 32'd4;

  always #5 sysclk = ~sysclk;

  core_sequencer dut (
    .sysclk(sysclk), .rst_in(rst_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
    .instr_out(instr_out), .pc_out(pc_out), .pc_next_in(pc_next_in),
    .mem_op_in(mem_op_in), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_ack_in(dmem_ack_in), .dmem_rd_data_in(dmem_rd_data_in),
    .load_data_out(load_data_out), .reg_wr_en_in(reg_wr_en_in),
    .reg_wr_en_out(reg_wr_en_out), .retire_out(retire_out), .instret_out(instret_out),
    .trap_out(trap_out), .trap_cause_out(trap_cause_out)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] pc, instret, ld;
  } ev_t;
  ev_t sb[$];

  logic [31:0] exp_pc = 0, exp_instret = 0, exp_ld = 0;

  task automatic push_ret(input logic [31:0] nxt);
    sb.push_back('{trap: 1'b0, cause: 2'b00, pc: exp_pc, instret: exp_instret, ld: exp_ld});
    exp_pc = nxt;
    exp_instret++;
  endtask

  task automatic push_trap(input logic [1:0] cause);
    sb.push_back('{trap: 1'b1, cause: cause, pc: exp_pc, instret: exp_instret, ld: exp_ld});
    exp_pc = 32'h100;
  endtask

  always @(negedge sysclk) begin : mon
    ev_t e;
    #2;
    if (!rst_in && (retire_out || trap_out)) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ev_kind", 32'(trap_out), 32'(e.trap));
        chk("ev_pc", pc_out, e.pc);
        if (e.trap) chk("ev_cause", 32'(trap_cause_out), 32'(e.cause));
        else begin
          chk("ev_instret", instret_out, e.instret);
          chk("ev_ld", load_data_out, e.ld);
        end
      end
    end
  end

  // Runs one instruction from a FETCH cycle; iw/dw are wait cycles before ack (-1: never).
  task automatic run(input logic [1:0] op, input int iw, input int dw, input logic [31:0] rd,
                     output int cyc, output int dreq, output int dwe, output int wr);
    int fc, mc;
    fc = 0; mc = 0; cyc = 0; dreq = 0; dwe = 0; wr = 0;
    mem_op_in = op;
    dmem_rd_data_in = rd;
    while (cyc < 64) begin
      cyc++;
      imem_ack_in = imem_req_out && (fc == iw);
      dmem_ack_in = dmem_req_out && (mc == dw);
      if (imem_req_out) fc++;
      if (dmem_req_out) mc++;
      #1;
      dreq += int'(dmem_req_out);
      dwe  += int'(dmem_req_out && dmem_we_out);
      wr   += int'(reg_wr_en_out);
      if (retire_out || trap_out) break;
      @(negedge sysclk);
    end
    imem_ack_in = 0;
    dmem_ack_in = 0;
    mem_op_in = 0;
    @(negedge sysclk);
  endtask

  int cyc, dreq, dwe, wr;

  initial begin
    imem_ack_in = 1;
    repeat (3) @(negedge sysclk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h13);
    chk("rst_ld", load_data_out, 32'h0);
    chk("rst_instret", instret_out, 32'h0);
    chk("rst_cause", 32'(trap_cause_out), 32'h0);
    chk("rst_strobes", {28'h0, imem_req_out, dmem_req_out, retire_out, trap_out}, 32'h0);

    // NOP stream with ack held high
    push_ret(32'h4); push_ret(32'h8); push_ret(32'hC);
    @(negedge sysclk);
    rst_in = 0;
    #1 chk("idle_req", 32'(imem_req_out), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge sysclk);
      #1;
      chk("nop_retire", 32'(retire_out), 32'((i % 3) == 0));
      if ((i % 3) == 1) chk("nop_addr", imem_addr_out, 32'(4 * (i / 3)));
    end
    @(negedge sysclk);
    imem_ack_in = 0;
    #1;
    chk("nop_instret", instret_out, 32'd3);
    chk("nop_addr4", imem_addr_out, 32'hC);

    // load, 2 dmem wait cycles
    exp_ld = 32'hDEADBEEF;
    push_ret(exp_pc + 4);
    run(2'b01, 0, 2, 32'hDEADBEEF, cyc, dreq, dwe, wr);
    chk("ld_cyc", cyc, 6);
    chk("ld_dreq", dreq, 3);
    chk("ld_we", dwe, 0);
    chk("ld_wr", wr, 1);
    chk("ld_data", load_data_out, 32'hDEADBEEF);

    // store, zero wait, no register write
    reg_wr_en_in = 0;
    push_ret(exp_pc + 4);
    run(2'b10, 0, 0, 32'h12345678, cyc, dreq, dwe, wr);
    chk("st_cyc", cyc, 4);
    chk("st_we", dwe, 1);
    chk("st_wr", wr, 0);
    chk("st_ld", load_data_out, 32'hDEADBEEF);
    reg_wr_en_in = 1;

    // fetch timeout
    push_trap(2'b01);
    run(2'b00, -1, 0, 0, cyc, dreq, dwe, wr);
    chk("itmo_cyc", cyc, 17);
    #1;
    chk("itmo_addr", imem_addr_out, 32'h100);
    chk("itmo_instret", instret_out, exp_instret);
    chk("itmo_cause", 32'(trap_cause_out), 32'h1);

    // ack on the last countdown cycle wins
    push_ret(exp_pc + 4);
    run(2'b00, 15, 0, 0, cyc, dreq, dwe, wr);
    chk("iack16_cyc", cyc, 18);

    // misaligned next pc
    use_tgt = 1; pc_tgt = 32'h6;
    push_trap(2'b11);
    run(2'b00, 0, 0, 0, cyc, dreq, dwe, wr);
    use_tgt = 0;
    chk("mis_cyc", cyc, 4);
    chk("mis_wr", wr, 0);
    #1 chk("mis_pc", pc_out, 32'h100);

    // data timeout
    push_trap(2'b10);
    run(2'b01, 0, -1, 0, cyc, dreq, dwe, wr);
    chk("dtmo_cyc", cyc, 19);
    chk("dtmo_dreq", dreq, 16);

    // reset during a MEM wait
    mem_op_in = 2'b01;
    imem_ack_in = 1;
    @(negedge sysclk);
    imem_ack_in = 0;
    @(negedge sysclk);
    #1 chk("mrst_dreq_pre", 32'(dmem_req_out), 32'h1);
    #2 rst_in = 1;
    #1;
    chk("mrst_dreq", 32'(dmem_req_out), 32'h0);
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_instret", instret_out, 32'h0);
    chk("mrst_retire", 32'(retire_out | reg_wr_en_out), 32'h0);
    mem_op_in = 0;
    exp_pc = 0; exp_instret = 0; exp_ld = 0;
    @(negedge sysclk);
    rst_in = 0;
    @(negedge sysclk);

    // counter wrap
    dut.instret_q = 32'hFFFF_FFFF;
    exp_instret = 32'hFFFF_FFFF;
    push_ret(32'h4);
    run(2'b00, 0, 0, 0, cyc, dreq, dwe, wr);
    #1 chk("wrap_instret", instret_out, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
